cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
- Parametrised, clocked successor to the combinational CNN layer decoder.
- Runs NUM_LAYERS layers from a host command byte: one layer alone, or the whole chain back to back.
- Releases each layer's memory resets from per-layer config masks and drives the MAC and pool enables.
- Waits for sticky-captured done flags, then reports completion on return_ctrl. Sits between the host register file and the layer datapath.

Parameters:
- NUM_LAYERS, 6: number of layers; layer k is config slot k-1.
- NUM_MEMS, 12: number of memory read/write counters with reset/done pairs.
- CTRL_W, 8: width of the command and status bytes; must satisfy 2^CTRL_W-1 > NUM_LAYERS.
- TIMEOUT_CYCLES, 65535: watchdog limit in RUN cycles (used only with TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ctrl  in  CTRL_W  command: 0 = idle/abort; 1..NUM_LAYERS = run that single layer; all-ones = run all layers in chain
- cfg_mem_mask  in  NUM_LAYERS*NUM_MEMS  per-layer set of memories released and awaited; slot k-1 at [k*NUM_MEMS-1 -: NUM_MEMS]
- cfg_is_pool  in  NUM_LAYERS  1 = pooling layer, 0 = MAC layer
- cfg_mac_layer  in  2*NUM_LAYERS  per-layer MAC mode code
- mem_done  in  NUM_MEMS  done flags from memory counters (may pulse or hold)
- mem_reset  out  NUM_MEMS  per-memory reset (1 = held in reset)
- layer_onehot  out  NUM_LAYERS  active-layer select
- mac_enable  out  1  MAC enable
- rmac  out  1  MAC accumulator reset
- pooling_layer  out  1  pooling path select
- mac_layer  out  2  MAC mode of the active layer
- return_ctrl  out  CTRL_W  status: completed layer index, or 0
- busy  out  1  high in ARM, RUN and chained DONE
- err  out  1  watchdog error

Behaviour:
- States: IDLE, ARM, RUN, DONE, ERR. All outputs are registered.
- Reset (asynchronous) and IDLE output values:
  - mem_reset = all 1s, rmac = 1
  - mac_enable, pooling_layer, busy, err = 0
  - layer_onehot, mac_layer, return_ctrl = 0
  - cur = 0, sticky = 0
- IDLE:
  - ctrl in 1..NUM_LAYERS: latch cmd, cur = ctrl, chain = 0; go to ARM.
  - ctrl all-ones: cur = 1, chain = 1; go to ARM.
  - Any other value: ignored, stay in IDLE.
- ARM (exactly 1 cycle):
  - mem_reset all 1s, rmac = 1, sticky cleared.
  - layer_onehot = 1<<(cur-1), busy = 1.
  - Go to RUN.
- RUN:
  - mem_reset = ~mask[cur].
  - MAC layer: mac_enable = 1, rmac = 0.
  - Pool layer: pooling_layer = 1, rmac = 1, mac_enable = 0.
  - mac_layer = cfg code for cur.
  - sticky |= mem_done & mask each cycle.
  - When (sticky | (mem_done & mask)) == mask, go to DONE; the DONE outputs appear 1 cycle after the completing done flag is sampled.
  - Empty mask: RUN lasts exactly 1 cycle.
- DONE:
  - mem_reset all 1s, enables 0, rmac = 1, layer_onehot held, return_ctrl = cur.
  - Chain and cur < NUM_LAYERS: 1 cycle, then cur += 1 and go to ARM.
  - Single mode, or chain at the last layer: hold, busy = 0, until ctrl differs from the latched command; then go to IDLE (return_ctrl = 0).
- Abort: ctrl == 0 in any state gives IDLE outputs on the next cycle; an in-flight layer is discarded.
- A non-zero ctrl change during ARM/RUN, or during chained DONE, is ignored; the command is latched at start.
- Config ports are sampled live and must be held stable while busy.
- Simultaneous done and abort: abort wins.

Optional Feature:
- Macro: CNN_SEQ_TIMEOUT_EN.
- With the macro:
  - A 32-bit counter clears in ARM and increments each RUN cycle.
  - At count == TIMEOUT_CYCLES-1 with completion not met, the FSM goes to ERR: err = 1, all resets asserted, enables 0, return_ctrl = 0.
  - ERR exits to IDLE only when ctrl == 0.
  - Completion in the same cycle as the limit wins.
- Without the macro: no counter, err tied 0, ERR state unreachable.

Test Plan:
- Reset mid-RUN (ctrl = 2, assert reset 1 cycle) -> same cycle: mem_reset = 12'hFFF, mac_enable = 0, return_ctrl = 0, busy = 0.
- ctrl = 2, mask[2] = 12'h00B, mem_done bits 0/1/3 pulse in separate cycles -> return_ctrl = 2 exactly 1 cycle after bit 3, held until ctrl = 0; then return_ctrl = 0.
- ctrl = 8'hFF, all 6 layers with single-bit masks, done 4 cycles after RUN entry -> return_ctrl steps 1..6 (1-cycle pulses), ARM between layers, ends holding 6 with busy = 0.
- ctrl = 3 (pool), ctrl = 9, ctrl = 0 mid-RUN -> pool: pooling_layer = 1, rmac = 1, mac_enable = 0; ctrl = 9 ignored in IDLE; ctrl = 0 gives IDLE next cycle with no return_ctrl.
- CNN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 16, ctrl = 4, no done -> err = 1 after 16 RUN cycles; ctrl = 0 clears it. Done at cycle 16 -> return_ctrl = 4, err = 0.
- Empty mask for layer 1, ctrl = 1 -> ARM, 1-cycle RUN, DONE with return_ctrl = 1 on the 3rd cycle after command.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Clocked CNN layer sequencer: runs one layer or the whole chain from a host command byte.
// Optional watchdog (ERR state) is built when CNN_SEQ_TIMEOUT_EN is defined.
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS     = 6,
    parameter int NUM_MEMS       = 12,
    parameter int CTRL_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CTRL_W-1:0]              ctrl,
    input  logic [NUM_LAYERS*NUM_MEMS-1:0] cfg_mem_mask,
    input  logic [NUM_LAYERS-1:0]          cfg_is_pool,
    input  logic [2*NUM_LAYERS-1:0]        cfg_mac_layer,
    input  logic [NUM_MEMS-1:0]            mem_done,
    output logic [NUM_MEMS-1:0]            mem_reset,
    output logic [NUM_LAYERS-1:0]          layer_onehot,
    output logic                           mac_enable,
    output logic                           rmac,
    output logic                           pooling_layer,
    output logic [1:0]                     mac_layer,
    output logic [CTRL_W-1:0]              return_ctrl,
    output logic                           busy,
    output logic                           err
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DONE, S_ERR} state_t;

    localparam logic [CTRL_W-1:0] LAST = CTRL_W'(NUM_LAYERS);

    if (CTRL_W < 31 && ((1 << CTRL_W) - 1) <= NUM_LAYERS) begin : g_bad_ctrl_w
        $error("CTRL_W too narrow to encode NUM_LAYERS plus the chain command");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                  state_q;
    logic [CTRL_W-1:0]       cur_q;
    logic [CTRL_W-1:0]       cmd_q;
    logic                    chain_q;
    logic [NUM_MEMS-1:0]     sticky_q;
    logic [NUM_MEMS-1:0]     sticky_d;
    logic [NUM_MEMS-1:0]     mem_reset_q;
    logic [NUM_LAYERS-1:0]   onehot_q;
    logic                    mac_enable_q;
    logic                    rmac_q;
    logic                    pool_q;
    logic [1:0]              mac_layer_q;
    logic [CTRL_W-1:0]       ret_q;
    logic                    busy_q;
    logic                    err_q;

    logic [NUM_MEMS-1:0]     cur_mask;
    logic                    cur_pool;
    logic [1:0]              cur_code;
    logic                    tmo_hit;
    logic                    cmd_single;
    logic                    cmd_chain;

    function automatic logic [NUM_LAYERS-1:0] onehot_of(input logic [CTRL_W-1:0] l);
        logic [NUM_LAYERS-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (l == CTRL_W'(k + 1)) oh[k] = 1'b1;
        end
        return oh;
    endfunction

    // Config of the layer currently selected by cur_q; slot k-1 belongs to layer k.
    always_comb begin
        cur_mask = '0;
        cur_pool = 1'b0;
        cur_code = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (cur_q == CTRL_W'(k + 1)) begin
                cur_mask = cfg_mem_mask[k*NUM_MEMS +: NUM_MEMS];
                cur_pool = cfg_is_pool[k];
                cur_code = cfg_mac_layer[2*k +: 2];
            end
        end
    end

    assign sticky_d   = sticky_q | (mem_done & cur_mask);
    assign cmd_single = (ctrl != '0) && (ctrl <= LAST);
    assign cmd_chain  = (ctrl == '1);

`ifdef CNN_SEQ_TIMEOUT_EN
    logic [31:0] tmo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (state_q == S_ARM) begin
            tmo_q <= '0;
        end else if (state_q == S_RUN) begin
            tmo_q <= tmo_q + 32'd1;
        end
    end

    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            cmd_q        <= '0;
            chain_q      <= 1'b0;
            sticky_q     <= '0;
            mem_reset_q  <= '1;
            onehot_q     <= '0;
            mac_enable_q <= 1'b0;
            rmac_q       <= 1'b1;
            pool_q       <= 1'b0;
            mac_layer_q  <= '0;
            ret_q        <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Safe output values; each state below overrides only what it drives.
            mem_reset_q  <= '1;
            mac_enable_q <= 1'b0;
            rmac_q       <= 1'b1;
            pool_q       <= 1'b0;
            mac_layer_q  <= '0;
            ret_q        <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            if (ctrl == '0) begin
                state_q  <= S_IDLE;
                cur_q    <= '0;
                chain_q  <= 1'b0;
                sticky_q <= '0;
                onehot_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd_single || cmd_chain) begin
                            state_q  <= S_ARM;
                            cmd_q    <= ctrl;
                            cur_q    <= cmd_chain ? CTRL_W'(1) : ctrl;
                            chain_q  <= cmd_chain;
                            sticky_q <= '0;
                            onehot_q <= onehot_of(cmd_chain ? CTRL_W'(1) : ctrl);
                            busy_q   <= 1'b1;
                        end
                    end
                    S_ARM: begin
                        state_q      <= S_RUN;
                        sticky_q     <= '0;
                        mem_reset_q  <= ~cur_mask;
                        mac_enable_q <= ~cur_pool;
                        rmac_q       <= cur_pool;
                        pool_q       <= cur_pool;
                        mac_layer_q  <= cur_code;
                        busy_q       <= 1'b1;
                    end
                    S_RUN: begin
                        sticky_q <= sticky_d;
                        if (sticky_d == cur_mask) begin
                            state_q <= S_DONE;
                            ret_q   <= cur_q;
                            busy_q  <= chain_q && (cur_q != LAST);
                        end else if (tmo_hit) begin
                            state_q  <= S_ERR;
                            onehot_q <= '0;
                            err_q    <= 1'b1;
                        end else begin
                            mem_reset_q  <= ~cur_mask;
                            mac_enable_q <= ~cur_pool;
                            rmac_q       <= cur_pool;
                            pool_q       <= cur_pool;
                            mac_layer_q  <= cur_code;
                            busy_q       <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (chain_q && (cur_q != LAST)) begin
                            state_q  <= S_ARM;
                            cur_q    <= cur_q + CTRL_W'(1);
                            sticky_q <= '0;
                            onehot_q <= onehot_of(cur_q + CTRL_W'(1));
                            busy_q   <= 1'b1;
                        end else if (ctrl != cmd_q) begin
                            state_q  <= S_IDLE;
                            cur_q    <= '0;
                            chain_q  <= 1'b0;
                            onehot_q <= '0;
                        end else begin
                            ret_q <= cur_q;
                        end
                    end
                    S_ERR: begin
                        err_q <= 1'b1;
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        onehot_q <= '0;
                    end
                endcase
            end
        end
    end

    assign mem_reset     = mem_reset_q;
    assign layer_onehot  = onehot_q;
    assign mac_enable    = mac_enable_q;
    assign rmac          = rmac_q;
    assign pooling_layer = pool_q;
    assign mac_layer     = mac_layer_q;
    assign return_ctrl   = ret_q;
    assign busy          = busy_q;
    assign err           = err_q;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: transaction-level model plus directed pins.
// Watchdog scenarios run when CNN_SEQ_TIMEOUT_EN is defined.
module tb_cnn_layer_sequencer;
    localparam int NL  = 6;
    localparam int NM  = 12;
    localparam int CW  = 8;
    localparam int TMO_CYC = 16;
`ifdef CNN_SEQ_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    localparam logic [2:0] P_IDLE = 3'd0, P_ARM = 3'd1, P_RUN = 3'd2, P_DONE = 3'd3, P_ERR = 3'd4;

    logic            clk = 1'b0;
    logic            reset;
    logic [CW-1:0]   ctrl;
    logic [NL*NM-1:0] cfg_mem_mask;
    logic [NL-1:0]   cfg_is_pool;
    logic [2*NL-1:0] cfg_mac_layer;
    logic [NM-1:0]   mem_done;
    logic [NM-1:0]   mem_reset;
    logic [NL-1:0]   layer_onehot;
    logic            mac_enable;
    logic            rmac;
    logic            pooling_layer;
    logic [1:0]      mac_layer;
    logic [CW-1:0]   return_ctrl;
    logic            busy;
    logic            err;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    cnn_layer_sequencer #(
        .NUM_LAYERS(NL), .NUM_MEMS(NM), .CTRL_W(CW), .TIMEOUT_CYCLES(TMO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .ctrl(ctrl),
        .cfg_mem_mask(cfg_mem_mask), .cfg_is_pool(cfg_is_pool), .cfg_mac_layer(cfg_mac_layer),
        .mem_done(mem_done), .mem_reset(mem_reset), .layer_onehot(layer_onehot),
        .mac_enable(mac_enable), .rmac(rmac), .pooling_layer(pooling_layer),
        .mac_layer(mac_layer), .return_ctrl(return_ctrl), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  phase;
        logic [7:0]  layer;
        logic        chain;
        logic [7:0]  cmd;
        logic [11:0] seen;
        int          runcnt;
    } mstate_t;

    typedef struct packed {
        logic [11:0] mem_reset;
        logic [5:0]  onehot;
        logic        mac_en;
        logic        rmac;
        logic        pool;
        logic [1:0]  code;
        logic [7:0]  ret;
        logic        busy;
        logic        err;
    } out_t;

    mstate_t m = '0;

    function automatic logic [11:0] mask_of(input logic [7:0] l);
        if (l < 8'd1 || l > 8'(NL)) return 12'h000;
        return cfg_mem_mask[(int'(l) - 1)*NM +: NM];
    endfunction

    // One host-visible step of the sequencer, from the behavioural rules.
    function automatic mstate_t step(input mstate_t s, input logic [7:0] c, input logic [11:0] d);
        mstate_t n;
        logic [11:0] mk;
        n = s;
        if (c == 8'd0) return mstate_t'(0);
        case (s.phase)
            P_IDLE: begin
                if (c >= 8'd1 && c <= 8'(NL)) begin
                    n.phase = P_ARM; n.layer = c; n.chain = 1'b0; n.cmd = c;
                end else if (c == 8'hFF) begin
                    n.phase = P_ARM; n.layer = 8'd1; n.chain = 1'b1; n.cmd = c;
                end
            end
            P_ARM: begin
                n.phase = P_RUN; n.seen = '0; n.runcnt = 0;
            end
            P_RUN: begin
                mk = mask_of(s.layer);
                n.seen = s.seen | (d & mk);
                n.runcnt = s.runcnt + 1;
                if (n.seen == mk) n.phase = P_DONE;
                else if (TMO && n.runcnt == TMO_CYC) n.phase = P_ERR;
            end
            P_DONE: begin
                if (s.chain && s.layer < 8'(NL)) begin
                    n.layer = s.layer + 8'd1; n.phase = P_ARM;
                end else if (c != s.cmd) begin
                    n = mstate_t'(0);
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic out_t expect_of(input mstate_t s);
        out_t e;
        e = '0;
        e.mem_reset = 12'hFFF;
        e.rmac = 1'b1;
        if (s.phase == P_ARM || s.phase == P_RUN || s.phase == P_DONE)
            e.onehot = 6'(1) << (s.layer - 8'd1);
        case (s.phase)
            P_ARM: e.busy = 1'b1;
            P_RUN: begin
                e.busy = 1'b1;
                e.mem_reset = ~mask_of(s.layer);
                e.pool = cfg_is_pool[int'(s.layer) - 1];
                e.mac_en = ~e.pool;
                e.rmac = e.pool;
                e.code = cfg_mac_layer[2*(int'(s.layer) - 1) +: 2];
            end
            P_DONE: begin
                e.ret = s.layer;
                e.busy = s.chain && (s.layer < 8'(NL));
            end
            P_ERR: e.err = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic out_t dut_out();
        out_t g;
        g = {mem_reset, layer_onehot, mac_enable, rmac, pooling_layer, mac_layer, return_ctrl, busy, err};
        return g;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else m <= step(m, ctrl, mem_done);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) chk("outputs", 64'(dut_out()), 64'(expect_of(m)));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input int l, input logic [11:0] v);
        cfg_mem_mask[(l - 1)*NM +: NM] = v;
    endtask

    task automatic rand_cfg();
        for (int l = 1; l <= NL; l++) begin
            if ($urandom_range(0, 4) == 0) set_mask(l, 12'h000);
            else set_mask(l, 12'($urandom) & 12'($urandom));
        end
        cfg_is_pool   = 6'($urandom);
        cfg_mac_layer = 12'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int q[$];
        logic [7:0] prev;
        int r;
        reset = 1'b1;
        ctrl = '0;
        mem_done = '0;
        rand_cfg();
        #1;
        cmp_on = 1'b1;
        chk("rst_mem_reset", mem_reset, 12'hFFF);
        chk("rst_rmac", rmac, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ret", return_ctrl, 0);
        chk("rst_onehot", layer_onehot, 0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset in the middle of a RUN
        set_mask(2, 12'h0F3);
        cfg_is_pool[1] = 1'b0;
        ctrl = 8'd2;
        tick(3);
        chk("pre_rst_mac_en", mac_enable, 1);
        reset = 1'b1;
        #1;
        chk("midrst_mem_reset", mem_reset, 12'hFFF);
        chk("midrst_mac_en", mac_enable, 0);
        chk("midrst_ret", return_ctrl, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ctrl = 8'd0;
        tick(1);

        // Layer 2 with three done pulses in separate cycles
        set_mask(2, 12'h00B);
        ctrl = 8'd2;
        tick(2);
        mem_done = 12'h001 | (12'($urandom) & ~12'h00B);
        tick(1);
        mem_done = 12'h002 | (12'($urandom) & ~12'h00B);
        tick(1);
        chk("l2_ret_before", return_ctrl, 0);
        mem_done = 12'h008;
        tick(1);
        chk("l2_ret_after_bit3", return_ctrl, 2);
        mem_done = '0;
        tick(3);
        chk("l2_ret_held", return_ctrl, 2);
        chk("l2_busy_held", busy, 0);
        ctrl = 8'd0;
        tick(1);
        chk("l2_ret_cleared", return_ctrl, 0);

        // Whole chain, single-bit masks, done on the 4th RUN cycle
        for (int l = 1; l <= NL; l++) set_mask(l, 12'(1) << $urandom_range(0, NM - 1));
        cfg_is_pool = 6'($urandom);
        cfg_mac_layer = 12'($urandom);
        ctrl = 8'hFF;
        prev = 8'd0;
        for (int i = 0; i < 150 && q.size() < NL; i++) begin
            tick(1);
            if (return_ctrl != 8'd0 && return_ctrl != prev) q.push_back(int'(return_ctrl));
            prev = return_ctrl;
            mem_done = (m.phase == P_RUN && m.runcnt == 3) ? mask_of(m.layer) : 12'h000;
        end
        chk("chain_count", q.size(), NL);
        for (int i = 0; i < q.size(); i++) chk("chain_seq", q[i], i + 1);
        tick(2);
        chk("chain_end_ret", return_ctrl, 6);
        chk("chain_end_busy", busy, 0);
        mem_done = '0;
        ctrl = 8'd0;
        tick(1);

        // Pool layer, out-of-range command, abort mid-RUN
        set_mask(3, 12'h0F0);
        cfg_is_pool[2] = 1'b1;
        ctrl = 8'd3;
        tick(3);
        chk("pool_sel", pooling_layer, 1);
        chk("pool_rmac", rmac, 1);
        chk("pool_mac_en", mac_enable, 0);
        chk("pool_mem_reset", mem_reset, 12'hF0F);
        ctrl = 8'd0;
        tick(1);
        chk("abort_busy", busy, 0);
        chk("abort_ret", return_ctrl, 0);
        chk("abort_mem_reset", mem_reset, 12'hFFF);
        ctrl = 8'd9;
        tick(2);
        chk("cmd9_busy", busy, 0);
        chk("cmd9_onehot", layer_onehot, 0);
        ctrl = 8'd0;
        tick(1);

        // Empty mask: ARM, one RUN cycle, DONE on the third cycle
        set_mask(1, 12'h000);
        ctrl = 8'd1;
        tick(1);
        chk("empty_arm_onehot", layer_onehot, 1);
        chk("empty_arm_busy", busy, 1);
        tick(1);
        chk("empty_run_ret", return_ctrl, 0);
        tick(1);
        chk("empty_done_ret", return_ctrl, 1);
        ctrl = 8'd0;
        tick(1);

`ifdef CNN_SEQ_TIMEOUT_EN
        set_mask(4, 12'h3C0);
        mem_done = '0;
        ctrl = 8'd4;
        tick(17);
        chk("tmo_err_early", err, 0);
        tick(1);
        chk("tmo_err", err, 1);
        chk("tmo_ret", return_ctrl, 0);
        chk("tmo_mem_reset", mem_reset, 12'hFFF);
        ctrl = 8'd0;
        tick(1);
        chk("tmo_err_clear", err, 0);
        ctrl = 8'd4;
        tick(17);
        mem_done = 12'h3C0;
        tick(1);
        chk("tmo_done_wins_ret", return_ctrl, 4);
        chk("tmo_done_wins_err", err, 0);
        mem_done = '0;
        ctrl = 8'd0;
        tick(1);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            if (m.phase == P_IDLE && $urandom_range(0, 3) == 0) rand_cfg();
            if ($urandom_range(0, 5) == 0) begin
                r = int'($urandom_range(0, 99));
                if (r < 25) ctrl = 8'd0;
                else if (r < 65) ctrl = 8'($urandom_range(1, NL));
                else if (r < 85) ctrl = 8'hFF;
                else ctrl = 8'($urandom_range(NL + 1, 254));
            end
            mem_done = 12'($urandom) & 12'($urandom);
            tick(1);
        end
        ctrl = 8'd0;
        mem_done = '0;
        tick(2);
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
